uart_log_arbiter: RTL and testbench

- Round-robin arbiter that shares one buffered UART logger between N_REQ independent byte producers.
- Producers each present whole messages as byte streams with a last flag. The arbiter locks the grant to one producer until its message ends, so log lines never interleave.
- It drives the logger's level-sensitive valid/ready input with the required one-cycle pulse and the one-cycle gap after every byte.
- Sits between debug/status sources and the UART logger instance.

---
 rtl/uart_log_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_uart_log_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_log_arbiter.sv
// ---------------------------------------------------------------------------
// uart_log_arbiter
//
// Round-robin arbiter that shares one buffered UART logger between N_REQ
// byte producers. A producer that wins arbitration keeps the grant until its
// message ends (last flag) or, when MAX_BURST is non-zero, until it has sent
// MAX_BURST bytes. This keeps log lines from interleaving. Every byte is
// handed to the logger as a one-cycle u_valid pulse followed by a one-cycle
// gap, which the logger's level-sensitive handshake needs.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester byte valid                  [N_REQ]
//   req_data   per-requester byte, requester i at [8i+7:8i]  [8*N_REQ]
//   req_last   per-requester "final byte of message"     [N_REQ]
//   req_ready  per-requester accept (granted index only) [N_REQ]
//   grant      registered one-hot owner, zero when idle  [N_REQ]
//   u_data     registered byte to the logger             [8]
//   u_valid    registered one-cycle byte strobe
//   u_ready    logger can take a byte
//   busy       high whenever the FSM is not arbitrating
// ---------------------------------------------------------------------------
module uart_log_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         u_data,
    output logic               u_valid,
    input  logic               u_ready,
    output logic               busy
);

    localparam int PW     = $clog2(N_REQ);
    localparam int BW_RAW = $clog2(MAX_BURST + 1);
    localparam int BW     = (BW_RAW < 1) ? 1 : BW_RAW;
    localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        XFER = 2'd1,
        PUSH = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]      gidx_q,  gidx_d;
    logic [PW-1:0]      ptr_q,   ptr_d;
    logic [BW-1:0]      burst_q, burst_d;
    logic               last_q,  last_d;
    logic [7:0]         u_data_q, u_data_d;
    logic               u_valid_q, u_valid_d;

    // Per-requester byte lanes, so the granted byte is a plain array select.
    logic [7:0] req_bytes [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lanes
            assign req_bytes[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin pick: first set req_valid bit at or above the pointer,
    // wrapping. The loop walks offsets from high to low so that the lowest
    // offset (closest to the pointer) is the one left in sel_idx.
    // -----------------------------------------------------------------------
    logic          sel_found;
    logic [PW-1:0] sel_idx;
    logic [PW:0]   cand;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = {1'b0, ptr_q} + (PW+1)'(off);
            if (cand >= (PW+1)'(N_REQ)) begin
                cand = cand - (PW+1)'(N_REQ);
            end
            if (req_valid[cand[PW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PW-1:0];
            end
        end
    end

    // Grant is released after the gap cycle of the last byte of a message,
    // or once the burst limit is reached (limit 0 means no limit).
    logic release_now;
    assign release_now = last_q || ((MAX_BURST != 0) && (burst_q == BURST_LIMIT));

    logic [PW-1:0] ptr_after;
    assign ptr_after = (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + PW'(1);

    logic xfer_fire;
    assign xfer_fire = (state_q == XFER) && req_valid[gidx_q] && u_ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        burst_d   = burst_q;
        last_d    = last_q;
        u_data_d  = u_data_q;
        u_valid_d = 1'b0;

        case (state_q)
            ARB: begin
                if (sel_found) begin
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    gidx_d           = sel_idx;
                    burst_d          = '0;
                    state_d          = XFER;
                end
            end

            XFER: begin
                // Holding here with req_valid low keeps the lock, so a slow
                // producer cannot lose its line half-way through.
                if (xfer_fire) begin
                    u_data_d  = req_bytes[gidx_q];
                    u_valid_d = 1'b1;
                    last_d    = req_last[gidx_q];
                    // Saturating count; only matters for the unlimited case.
                    burst_d   = (burst_q == {BW{1'b1}}) ? burst_q : burst_q + BW'(1);
                    state_d   = PUSH;
                end
            end

            PUSH: begin
                // The logger captures the byte at the end of this cycle.
                state_d = GAP;
            end

            GAP: begin
                // One idle cycle lets the logger return to its wait state.
                if (release_now) begin
                    grant_d = '0;
                    ptr_d   = ptr_after;
                    state_d = ARB;
                end else begin
                    state_d = XFER;
                end
            end

            default: begin
                grant_d = '0;
                state_d = ARB;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            burst_q   <= '0;
            last_q    <= 1'b0;
            u_data_q  <= 8'h00;
            u_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            burst_q   <= burst_d;
            last_q    <= last_d;
            u_data_q  <= u_data_d;
            u_valid_q <= u_valid_d;
        end
    end

    // Only the granted requester sees ready, and only while in XFER.
    assign req_ready = ((state_q == XFER) && u_ready) ? grant_q : '0;
    assign grant     = grant_q;
    assign u_data    = u_data_q;
    assign u_valid   = u_valid_q;
    assign busy      = (state_q != ARB);

endmodule

// File: tb/tb_uart_log_arbiter.sv
module tb_uart_log_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     grant;
    logic [7:0]       u_data;
    logic             u_valid;
    logic             u_ready;
    logic             busy;

    uart_log_arbiter #(.N_REQ(N), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .u_data    (u_data),
        .u_valid   (u_valid),
        .u_ready   (u_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Producer byte queues: {last, data}
    logic [8:0]  txq [N][$];
    bit          hold [N];
    // Scoreboard: {requester[3:0], data[7:0]}
    logic [11:0] exp_q [$];
    int          pulse_cyc [$];
    int          cyc = 0;
    logic        prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (txq[i].size() > 0 && !hold[i]) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = txq[i][0][7:0];
                req_last[i]         = txq[i][0][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes mid-cycle, pop accepted bytes after the edge.
    task automatic tick();
        logic [N-1:0] fire;
        @(negedge clk);
        fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) void'(txq[i].pop_front());
        end
        drive();
    endtask

    task automatic load(input int r, input logic [7:0] d, input bit l);
        txq[r].push_back({l, d});
    endtask

    task automatic expect_byte(input int r, input logic [7:0] d);
        logic [3:0] rr;
        rr = 4'(r);
        exp_q.push_back({rr, d});
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (txq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(all_empty() && exp_q.size() == 0 && !busy) && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s timeout after %0d cycles, pending_exp=%0d", name, n, exp_q.size());
        end
    endtask

    // Monitor: every u_valid pulse is checked against the scoreboard.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && u_valid) begin
                $display("byte cyc=%0d grant=%b data=%02h", cyc, grant, u_data);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte act=%02h exp=none", u_data);
                end else begin
                    e = exp_q.pop_front();
                    check("u_data", {24'h0, u_data}, {24'h0, e[7:0]});
                    check("pulse_grant", {28'h0, grant}, 32'h1 << e[11:8]);
                end
                check("pulse_width_prev_low", {31'h0, prev_valid}, 32'h0);
                pulse_cyc.push_back(cyc);
            end
            prev_valid = rst_n & u_valid;
        end
    end

    initial begin
        int viol_g, viol_r, viol_v, n;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        u_ready   = 1'b1;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant",   {28'h0, grant},     32'h0);
        check("rst_u_valid", {31'h0, u_valid},   32'h0);
        check("rst_u_data",  {24'h0, u_data},    32'h0);
        check("rst_busy",    {31'h0, busy},      32'h0);
        check("rst_ready",   {28'h0, req_ready}, 32'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- test 1: req 1 sends "AB\n" ----------------
        pulse_cyc.delete();
        load(1, 8'h41, 0); load(1, 8'h42, 0); load(1, 8'h0A, 1);
        expect_byte(1, 8'h41); expect_byte(1, 8'h42); expect_byte(1, 8'h0A);
        drive();
        run_until_idle("t1_ab", 100);
        check("t1_pulses", pulse_cyc.size(), 3);
        if (pulse_cyc.size() == 3) begin
            check("t1_spacing0", pulse_cyc[1] - pulse_cyc[0], 3);
            check("t1_spacing1", pulse_cyc[2] - pulse_cyc[1], 3);
        end
        check("t1_grant_idle", {28'h0, grant}, 32'h0);
        check("t1_busy_idle",  {31'h0, busy},  32'h0);

        // ---------------- test 2: req 0 and req 2 together from reset ----------------
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        load(0, 8'h10, 0); load(0, 8'h11, 0); load(0, 8'h12, 1);
        load(2, 8'h20, 0); load(2, 8'h21, 0); load(2, 8'h22, 1);
        expect_byte(0, 8'h10); expect_byte(0, 8'h11); expect_byte(0, 8'h12);
        expect_byte(2, 8'h20); expect_byte(2, 8'h21); expect_byte(2, 8'h22);
        drive();
        run_until_idle("t2_pair", 200);
        // Pointer should now be 3: with 0 and 3 both asking, 3 goes first.
        load(0, 8'h30, 1);
        load(3, 8'h40, 1);
        expect_byte(3, 8'h40); expect_byte(0, 8'h30);
        drive();
        run_until_idle("t2_ptr3", 100);

        // ---------------- test 3: req 1 stalls mid-message ----------------
        load(1, 8'h50, 0); load(1, 8'h51, 0); load(1, 8'h52, 1);
        load(3, 8'h60, 1);
        expect_byte(1, 8'h50); expect_byte(1, 8'h51); expect_byte(1, 8'h52);
        expect_byte(3, 8'h60);
        drive();
        n = 0;
        while (txq[1].size() == 3 && n < 20) begin tick(); n++; end
        check("t3_first_byte_taken", txq[1].size(), 2);
        hold[1] = 1'b1;
        drive();
        tick(); tick();
        viol_g = 0; viol_r = 0; viol_v = 0;
        repeat (20) begin
            tick();
            if (grant !== 4'b0010) viol_g++;
            if (req_ready[3] !== 1'b0) viol_r++;
            if (u_valid !== 1'b0) viol_v++;
        end
        check("t3_grant_locked",  viol_g, 0);
        check("t3_ready3_low",    viol_r, 0);
        check("t3_u_valid_low",   viol_v, 0);
        hold[1] = 1'b0;
        drive();
        run_until_idle("t3_resume", 200);

        // ---------------- test 4: u_ready low for 50 cycles ----------------
        u_ready = 1'b0;
        load(2, 8'h70, 1);
        expect_byte(2, 8'h70);
        drive();
        tick();
        viol_g = 0; viol_r = 0; viol_v = 0;
        repeat (50) begin
            tick();
            if (grant !== 4'b0100) viol_g++;
            if (req_ready !== 4'b0000) viol_r++;
            if (u_valid !== 1'b0) viol_v++;
        end
        check("t4_grant_held",   viol_g, 0);
        check("t4_ready_low",    viol_r, 0);
        check("t4_u_valid_low",  viol_v, 0);
        u_ready = 1'b1;
        tick();
        check("t4_valid_after_ready", {31'h0, u_valid}, 32'h1);
        check("t4_data_after_ready",  {24'h0, u_data},  32'h70);
        run_until_idle("t4_done", 50);

        // ---------------- test 5: burst limit 4 ----------------
        for (int k = 0; k < 10; k++) load(0, 8'(8'h80 + k), (k == 9));
        load(1, 8'h90, 0); load(1, 8'h91, 1);
        for (int k = 0; k < 4; k++) expect_byte(0, 8'(8'h80 + k));
        expect_byte(1, 8'h90); expect_byte(1, 8'h91);
        for (int k = 4; k < 10; k++) expect_byte(0, 8'(8'h80 + k));
        drive();
        run_until_idle("t5_burst", 400);

        // ---------------- test 6: reset during PUSH ----------------
        load(2, 8'hB0, 0); load(2, 8'hB1, 1);
        drive();
        n = 0;
        while (txq[2].size() == 2 && n < 20) begin tick(); n++; end
        check("t6_in_push", {31'h0, u_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_u_valid", {31'h0, u_valid},   32'h0);
        check("t6_rst_grant",   {28'h0, grant},     32'h0);
        check("t6_rst_busy",    {31'h0, busy},      32'h0);
        check("t6_rst_ready",   {28'h0, req_ready}, 32'h0);
        txq[2].delete();
        drive();
        tick(); tick();
        rst_n = 1'b1;
        load(0, 8'hC0, 1);
        load(3, 8'hC3, 1);
        expect_byte(0, 8'hC0); expect_byte(3, 8'hC3);
        drive();
        run_until_idle("t6_restart", 100);

        check("exp_queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
